// File: rtl/byte_mem_responder.sv
// Byte-wide bus target: small byte memory with fixed wait states,
// valid/ready response channel and a side programming port.
module byte_mem_responder #(
  parameter int          ADDR_W      = 8,
  parameter int          DEPTH       = 32,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [7:0]  ERR_DATA    = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [7:0]        req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [7:0]        rsp_rdata_o,
  output logic              rsp_err_o,
  input  logic              prog_we_i,
  input  logic [ADDR_W-1:0] prog_addr_i,
  input  logic [7:0]        prog_data_i
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              valid_q, valid_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [7:0]        mem_q [DEPTH];

  logic              accept;
  logic              prog_ok;
  logic              acc_go;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [7:0]        acc_wdata;
  logic              acc_err;
  logic [7:0]        mem_rd;

  // Program writes take priority over requests in IDLE.
  assign req_ready_o = (state_q == S_IDLE) && !prog_we_i && !rst;
  assign accept      = req_valid_i && req_ready_o;
  assign prog_ok     = (state_q == S_IDLE) && prog_we_i &&
                       ({1'b0, prog_addr_i} < LIMIT);

  assign rsp_valid_o = valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  // With zero wait states the access uses the live request.
  always_comb begin
    acc_go    = 1'b0;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && WAIT_CYCLES == 0) begin
          acc_go    = 1'b1;
          acc_we    = req_we_i;
          acc_addr  = req_addr_i;
          acc_wdata = req_wdata_i;
        end
      end
      S_WAIT: acc_go = (cnt_q == 4'd0);
      default: acc_go = 1'b0;
    endcase
  end

  assign acc_err = ({1'b0, acc_addr} >= LIMIT);
  assign mem_rd  = mem_q[acc_addr[IDX_W-1:0]];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valid_d = valid_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          rdata_d = 8'h00;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (acc_go) begin
      valid_d = 1'b1;
      err_d   = acc_err;
      if (acc_we) begin
        rdata_d = 8'h00;
      end else begin
        rdata_d = acc_err ? ERR_DATA : mem_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      valid_q <= 1'b0;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (prog_ok) begin
      mem_q[prog_addr_i[IDX_W-1:0]] <= prog_data_i;
    end else if (acc_go && acc_we && !acc_err) begin
      mem_q[acc_addr[IDX_W-1:0]] <= acc_wdata;
    end
  end

endmodule
